// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every reset domain, releases them one by one in index order,
// and re-sequences on soft requests. Optional watchdog enabled by RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int N_DOMAINS   = 3,
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic [N_REQ-1:0]     i_soft_req,
    input  logic                 i_wdt_kick,
    output logic [N_DOMAINS-1:0] o_reset,
    output logic                 o_ready,
    output logic [2:0]           o_cause
);

    localparam int HS_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
`ifdef RESET_SEQ_WDT_EN
    localparam int CNT_MAX = (WDT_CYCLES > HS_MAX) ? WDT_CYCLES : HS_MAX;
`else
    localparam int CNT_MAX = HS_MAX;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [N_DOMAINS-1:0] reset_reg, reset_next;
    logic                 ready_reg, ready_next;
    logic [2:0]           cause_reg, cause_next;
    logic                 pend_reg, pend_next;
    logic [2:0]           pend_cause_reg, pend_cause_next;
    logic                 force_all, clr_step;
    logic                 req_any;
    logic [2:0]           req_cause;
    logic                 wdt_expire;

    // Lowest set request bit wins.
    always_comb begin
        req_cause = 3'd4;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_soft_req[k]) req_cause = 3'(4 + k);
        end
    end
    assign req_any = |i_soft_req;

`ifdef RESET_SEQ_WDT_EN
    logic [CNT_W-1:0] wdt_cnt_reg;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wdt_cnt_reg <= '0;
        end else if (state_reg != S_RUN || i_wdt_kick) begin
            wdt_cnt_reg <= '0;
        end else if (wdt_cnt_reg != CNT_W'(WDT_CYCLES - 1)) begin
            wdt_cnt_reg <= wdt_cnt_reg + CNT_W'(1);
        end
    end

    assign wdt_expire = (state_reg == S_RUN) && !i_wdt_kick &&
                        (wdt_cnt_reg == CNT_W'(WDT_CYCLES - 1));
`else
    logic unused_wdt;
    assign unused_wdt = i_wdt_kick ^ (WDT_CYCLES < 2);
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        ready_next      = 1'b0;
        cause_next      = cause_reg;
        pend_next       = pend_reg;
        pend_cause_next = pend_cause_reg;
        force_all       = 1'b0;
        clr_step        = 1'b0;
        case (state_reg)
            S_SYNC: begin
                force_all = 1'b1;
                cnt_next  = '0;
                idx_next  = '0;
                pend_next = 1'b0;
                if (sync_reg[1]) state_next = S_HOLD;
            end
            S_HOLD: begin
                pend_next = 1'b0;
                if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_next = S_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_reg == CNT_W'(STEP_CYCLES - 1)) begin
                    clr_step = 1'b1;
                    cnt_next = '0;
                    if (idx_reg == IDX_W'(N_DOMAINS - 1)) begin
                        state_next = S_RUN;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RUN: begin
                cnt_next = '0;
                // A request is latched on one edge and acted on at the next.
                if (pend_reg) begin
                    state_next = S_HOLD;
                    force_all  = 1'b1;
                    cause_next = pend_cause_reg;
                    pend_next  = 1'b0;
                end else begin
                    ready_next = 1'b1;
                    if (req_any) begin
                        pend_next       = 1'b1;
                        pend_cause_next = req_cause;
                    end else if (wdt_expire) begin
                        pend_next       = 1'b1;
                        pend_cause_next = 3'd1;
                    end
                end
            end
            default: begin
                state_next = S_HOLD;
                force_all  = 1'b1;
                cnt_next   = '0;
                idx_next   = '0;
                pend_next  = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_dom
        assign reset_next[gi] = force_all |
            (reset_reg[gi] & ~(clr_step & (idx_reg == IDX_W'(gi))));
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            sync_reg       <= 2'b00;
            state_reg      <= S_SYNC;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            reset_reg      <= '1;
            ready_reg      <= 1'b0;
            cause_reg      <= 3'd0;
            pend_reg       <= 1'b0;
            pend_cause_reg <= 3'd0;
        end else begin
            sync_reg       <= {sync_reg[0], 1'b1};
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            reset_reg      <= reset_next;
            ready_reg      <= ready_next;
            cause_reg      <= cause_next;
            pend_reg       <= pend_next;
            pend_cause_reg <= pend_cause_next;
        end
    end

    assign o_reset = reset_reg;
    assign o_ready = ready_reg;
    assign o_cause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer; release times come from closed-form formulas.
// Watchdog scenario is exercised when RESET_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

    localparam int ND      = 3;
    localparam int NR      = 2;
    localparam int HOLD    = 4;
    localparam int STEP    = 2;
    localparam int WDT     = 8;
    localparam int READY_C = HOLD + ND * STEP + 1;

    logic          clk = 1'b0;
    logic          areset_n = 1'b1;
    logic [NR-1:0] soft_req = '0;
    logic          wdt_kick = 1'b1;
    logic [ND-1:0] rst_out;
    logic          ready;
    logic [2:0]    cause;

    int checks = 0;
    int failures = 0;
    logic [2:0] last_cause = 3'd0;

    reset_sequencer #(
        .N_DOMAINS  (ND),
        .N_REQ      (NR),
        .HOLD_CYCLES(HOLD),
        .STEP_CYCLES(STEP),
        .WDT_CYCLES (WDT)
    ) dut (
        .i_clk     (clk),
        .i_areset_n(areset_n),
        .i_soft_req(soft_req),
        .i_wdt_kick(wdt_kick),
        .o_reset   (rst_out),
        .o_ready   (ready),
        .o_cause   (cause)
    );

    always #5 clk = ~clk;

    // Domain k is held until cycle HOLD + (k+1)*STEP.
    function automatic logic [ND-1:0] exp_reset(int c);
        logic [ND-1:0] r;
        for (int k = 0; k < ND; k++) r[k] = (c < HOLD + (k + 1) * STEP);
        return r;
    endfunction

    function automatic logic exp_ready(int c);
        return c >= READY_C;
    endfunction

    function automatic logic [2:0] exp_cause(logic [NR-1:0] r);
        logic [2:0] ec;
        ec = 3'd0;
        for (int k = NR - 1; k >= 0; k--) if (r[k]) ec = 3'(4 + k);
        return ec;
    endfunction

    task automatic test_reset();
        #2 areset_n = 1'b0;
        #1;
        checks++; if (rst_out !== '1) begin failures++; $display("FAIL reset_out got=%b exp=%b", rst_out, {ND{1'b1}}); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (cause !== 3'd0) begin failures++; $display("FAIL reset_cause got=%0d exp=0", cause); end
        repeat (2) @(negedge clk);
        checks++; if (rst_out !== '1 || ready !== 1'b0) begin failures++; $display("FAIL reset_held got=%b/%b exp=%b/0", rst_out, ready, {ND{1'b1}}); end
        $display("txn reset: outputs held in reset");
        last_cause = 3'd0;
    endtask

    task automatic test_power_on();
        int fall_e;
        int c;
        fall_e = -1;
        @(negedge clk);
        areset_n = 1'b1;
        for (int e = 1; e <= HOLD + STEP + 4; e++) begin
            @(negedge clk);
            if (rst_out[0] === 1'b0) begin
                fall_e = e;
                break;
            end
            checks++;
            if (rst_out !== '1 || ready !== 1'b0 || cause !== 3'd0) begin
                failures++; $display("FAIL pon_hold e=%0d got=%b/%b/%0d exp=%b/0/0", e, rst_out, ready, cause, {ND{1'b1}});
            end
        end
        checks++;
        if (fall_e < 0 || fall_e - (HOLD + STEP) < 2 || fall_e - (HOLD + STEP) > 3) begin
            failures++; $display("FAIL pon_sync_latency got=%0d exp=2..3", fall_e - (HOLD + STEP));
        end
        if (fall_e >= 0) begin
            c = HOLD + STEP;
            while (1) begin
                checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL pon_reset c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
                checks++; if (ready !== exp_ready(c)) begin failures++; $display("FAIL pon_ready c=%0d got=%b exp=%b", c, ready, exp_ready(c)); end
                checks++; if (cause !== 3'd0) begin failures++; $display("FAIL pon_cause c=%0d got=%0d exp=0", c, cause); end
                if (c == READY_C + 1) break;
                @(negedge clk);
                c++;
            end
        end
        $display("txn power_on: first release at edge %0d", fall_e);
        last_cause = 3'd0;
    endtask

    task automatic test_soft_request();
        logic [NR-1:0] r;
        logic [2:0]    ec;
        int            idle;
        for (int it = 0; it < 6; it++) begin
            r    = (it == 0) ? 2'b10 : (it == 1) ? 2'b11 : NR'($urandom_range(1, 3));
            ec   = exp_cause(r);
            idle = $urandom_range(0, 3);
            repeat (idle) @(negedge clk);
            soft_req = r;
            @(negedge clk);
            soft_req = '0;
            checks++;
            if (ready !== 1'b1 || rst_out !== '0 || cause !== last_cause) begin
                failures++; $display("FAIL soft_sample_edge got=%b/%b/%0d exp=1/000/%0d", ready, rst_out, cause, last_cause);
            end
            for (int c = 0; c <= READY_C; c++) begin
                @(negedge clk);
                checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL soft_reset c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
                checks++; if (ready !== exp_ready(c)) begin failures++; $display("FAIL soft_ready c=%0d got=%b exp=%b", c, ready, exp_ready(c)); end
                checks++; if (cause !== ec) begin failures++; $display("FAIL soft_cause c=%0d got=%0d exp=%0d", c, cause, ec); end
            end
            $display("txn soft_request: req=%b idle=%0d cause=%0d", r, idle, ec);
            last_cause = ec;
        end
    endtask

    task automatic test_request_during_seq();
        logic [NR-1:0] pr;
        int            pc;
        for (int it = 0; it < 3; it++) begin
            pr = NR'($urandom_range(1, 3));
            pc = (it == 0) ? $urandom_range(0, HOLD - 2) : $urandom_range(0, READY_C - 3);
            soft_req = 2'b01;
            @(negedge clk);
            soft_req = '0;
            for (int c = 0; c <= READY_C; c++) begin
                @(negedge clk);
                checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL ignore_reset c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
                checks++; if (ready !== exp_ready(c)) begin failures++; $display("FAIL ignore_ready c=%0d got=%b exp=%b", c, ready, exp_ready(c)); end
                checks++; if (cause !== 3'd4) begin failures++; $display("FAIL ignore_cause c=%0d got=%0d exp=4", c, cause); end
                if (c == pc) soft_req = pr;
                else if (c == pc + 1) soft_req = '0;
            end
            $display("txn request_during_seq: pulse=%b at cycle %0d ignored", pr, pc + 1);
            last_cause = 3'd4;
        end
    endtask

    task automatic test_back_to_back();
        soft_req = 2'b10;
        @(negedge clk);
        for (int c = 0; c <= READY_C; c++) begin
            @(negedge clk);
            checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL b2b_first_reset c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
            checks++; if (ready !== exp_ready(c)) begin failures++; $display("FAIL b2b_first_ready c=%0d got=%b exp=%b", c, ready, exp_ready(c)); end
        end
        soft_req = '0;
        for (int c = 0; c <= READY_C; c++) begin
            @(negedge clk);
            checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL b2b_second_reset c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
            checks++; if (ready !== exp_ready(c)) begin failures++; $display("FAIL b2b_second_ready c=%0d got=%b exp=%b", c, ready, exp_ready(c)); end
            checks++; if (cause !== 3'd5) begin failures++; $display("FAIL b2b_cause c=%0d got=%0d exp=5", c, cause); end
        end
        $display("txn back_to_back: held request re-sequenced once in S_RUN");
        last_cause = 3'd5;
    endtask

    task automatic test_watchdog();
`ifdef RESET_SEQ_WDT_EN
        wdt_kick = 1'b0;
        soft_req = 2'b01;
        @(negedge clk);
        soft_req = '0;
        for (int c = 0; c <= READY_C; c++) begin
            @(negedge clk);
            checks++; if (rst_out !== exp_reset(c) || ready !== exp_ready(c)) begin failures++; $display("FAIL wdt_pre c=%0d got=%b/%b exp=%b/%b", c, rst_out, ready, exp_reset(c), exp_ready(c)); end
        end
        for (int c = READY_C + 1; c <= READY_C + WDT; c++) begin
            @(negedge clk);
            if (c < READY_C + WDT) begin
                checks++; if (ready !== 1'b1 || rst_out !== '0) begin failures++; $display("FAIL wdt_wait c=%0d got=%b/%b exp=1/000", c, ready, rst_out); end
            end else begin
                checks++; if (rst_out !== '1 || ready !== 1'b0) begin failures++; $display("FAIL wdt_fire got=%b/%b exp=111/0", rst_out, ready); end
                checks++; if (cause !== 3'd1) begin failures++; $display("FAIL wdt_cause got=%0d exp=1", cause); end
            end
        end
        for (int c = 1; c <= READY_C; c++) begin
            @(negedge clk);
            checks++; if (rst_out !== exp_reset(c) || ready !== exp_ready(c) || cause !== 3'd1) begin failures++; $display("FAIL wdt_reseq c=%0d got=%b/%b/%0d exp=%b/%b/1", c, rst_out, ready, cause, exp_reset(c), exp_ready(c)); end
        end
        for (int i = 0; i < 40; i++) begin
            wdt_kick = (i % 5 == 0);
            @(negedge clk);
            checks++; if (ready !== 1'b1 || rst_out !== '0) begin failures++; $display("FAIL wdt_kicked i=%0d got=%b/%b exp=1/000", i, ready, rst_out); end
        end
        $display("txn watchdog: expiry re-sequenced with cause 1, kicks every 5 held it off");
        last_cause = 3'd1;
`else
        wdt_kick = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b1 || rst_out !== '0 || cause !== last_cause) begin failures++; $display("FAIL no_wdt i=%0d got=%b/%b/%0d exp=1/000/%0d", i, ready, rst_out, cause, last_cause); end
        end
        $display("txn watchdog: absent, no kicks caused no reset");
`endif
        wdt_kick = 1'b1;
    endtask

    task automatic test_async_mid_release();
        int stop_c;
        stop_c = $urandom_range(HOLD + STEP, READY_C - 2);
        soft_req = 2'b10;
        @(negedge clk);
        soft_req = '0;
        for (int c = 0; c <= stop_c; c++) begin
            @(negedge clk);
            checks++; if (rst_out !== exp_reset(c)) begin failures++; $display("FAIL async_pre c=%0d got=%b exp=%b", c, rst_out, exp_reset(c)); end
        end
        #2 areset_n = 1'b0;
        #1;
        checks++; if (rst_out !== '1) begin failures++; $display("FAIL async_reset got=%b exp=111", rst_out); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b exp=0", ready); end
        checks++; if (cause !== 3'd0) begin failures++; $display("FAIL async_cause got=%0d exp=0", cause); end
        @(negedge clk);
        checks++; if (rst_out !== '1 || cause !== 3'd0) begin failures++; $display("FAIL async_held got=%b/%0d exp=111/0", rst_out, cause); end
        $display("txn async_mid_release: reset dropped at cycle %0d", stop_c);
        last_cause = 3'd0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_request();
        test_request_during_seq();
        test_back_to_back();
        test_watchdog();
        test_async_mid_release();
        test_power_on();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
